elevator_car_ctrl: RTL and testbench

Car controller on the consuming side of the floor-request latches. The request bank (one flip-flop per floor, set by call buttons, cleared by this block) presents held requests on `req`. This block reads them, moves the car floor by floor with direction-preserving (SCAN) scheduling, opens the door at requested floors, and returns a one-cycle clear pulse to the latch it serviced. It sits between the request bank and the floor display and motor/door drivers.

---
 rtl/elevator_car_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: SCAN-scheduled car controller that services held floor-request latches.
// Latency: an IDLE decision takes one cycle; each floor takes TRAVEL_CYCLES; each door service takes DOOR_CYCLES.
// Backpressure: none; requests stay in their latches until req_clr pulses for the serviced floor.
// Ports: clk; emergency (sync active-high reset); req[FLOORS] held requests in;
//        req_clr[FLOORS] one-hot clear pulse out; floor, moving_up, moving_down, door_open status out.
module elevator_car_ctrl #(
  parameter int FLOORS        = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              emergency,
  input  logic [FLOORS-1:0] req,
  output logic [FLOORS-1:0] req_clr,
  output logic [FW-1:0]     floor,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR} state_t;

  state_t            state_q, state_d;
  logic              dir_up_q, dir_up_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [TW-1:0]     trav_q, trav_d;
  logic [DW-1:0]     door_q, door_d;
  logic [FLOORS-1:0] clr_q, clr_d;
  logic              mu_q, md_q, do_q;

  logic          here, above, below;
  logic [FW-1:0] next_up, next_dn;

  function automatic logic any_above(input logic [FLOORS-1:0] r, input logic [FW-1:0] f);
    logic a;
    a = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(f)) a = a | r[i];
    end
    return a;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] r, input logic [FW-1:0] f);
    logic b;
    b = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i < int'(f)) b = b | r[i];
    end
    return b;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] o;
    o    = '0;
    o[f] = 1'b1;
    return o;
  endfunction

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    floor_d  = floor_q;
    trav_d   = trav_q;
    door_d   = door_q;
    clr_d    = '0;
    here     = req[floor_q];
    above    = any_above(req, floor_q);
    below    = any_below(req, floor_q);
    next_up  = floor_q + FW'(1);
    next_dn  = floor_q - FW'(1);

    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_DOOR;
          door_d  = '0;
          clr_d   = onehot(floor_q);
        end else if (dir_up_q && above) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
          trav_d   = '0;
        end else if (below) begin
          // Covers both "heading down with work below" and "heading up with nothing above".
          state_d  = S_MOVE_DOWN;
          dir_up_d = 1'b0;
          trav_d   = '0;
        end else if (above) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
          trav_d   = '0;
        end
      end

      S_MOVE_UP: begin
        if (floor_q == FW'(FLOORS - 1)) begin
          state_d = S_IDLE;
        end else if (trav_q == TW'(TRAVEL_CYCLES - 1)) begin
          // Arrival decision looks at the floor being entered, not the one being left.
          floor_d = next_up;
          trav_d  = '0;
          if (req[next_up]) begin
            state_d = S_DOOR;
            door_d  = '0;
            clr_d   = onehot(next_up);
          end else if (!any_above(req, next_up)) begin
            state_d = S_IDLE;
          end
        end else begin
          trav_d = trav_q + TW'(1);
        end
      end

      S_MOVE_DOWN: begin
        if (floor_q == '0) begin
          state_d = S_IDLE;
        end else if (trav_q == TW'(TRAVEL_CYCLES - 1)) begin
          floor_d = next_dn;
          trav_d  = '0;
          if (req[next_dn]) begin
            state_d = S_DOOR;
            door_d  = '0;
            clr_d   = onehot(next_dn);
          end else if (!any_below(req, next_dn)) begin
            state_d = S_IDLE;
          end
        end else begin
          trav_d = trav_q + TW'(1);
        end
      end

      S_DOOR: begin
        // In the clear cycle the latch still shows the request being serviced,
        // so only a request seen after that cycle counts as a re-press.
        if (clr_q == '0 && here) begin
          door_d = '0;
          clr_d  = onehot(floor_q);
        end else if (door_q == DW'(DOOR_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          door_d = door_q + DW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (emergency) begin
      state_q  <= S_IDLE;
      dir_up_q <= 1'b1;
      floor_q  <= '0;
      trav_q   <= '0;
      door_q   <= '0;
      clr_q    <= '0;
      mu_q     <= 1'b0;
      md_q     <= 1'b0;
      do_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      floor_q  <= floor_d;
      trav_q   <= trav_d;
      door_q   <= door_d;
      clr_q    <= clr_d;
      mu_q     <= (state_d == S_MOVE_UP);
      md_q     <= (state_d == S_MOVE_DOWN);
      do_q     <= (state_d == S_DOOR);
    end
  end

  assign req_clr     = clr_q;
  assign floor       = floor_q;
  assign moving_up   = mu_q;
  assign moving_down = md_q;
  assign door_open   = do_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed bench for elevator_car_ctrl with a behavioural request latch.
// The latch clears a bit at the posedge following a req_clr pulse; outputs are sampled 1 time unit after posedge.
// Observed word per check: {floor[1:0], moving_up, moving_down, door_open, req_clr[3:0]}.
module tb_elevator_car_ctrl;

  logic       clk = 1'b0;
  logic       emergency;
  logic [3:0] req;
  logic [3:0] req_clr;
  logic [1:0] floor;
  logic       moving_up, moving_down, door_open;

  int checks   = 0;
  int failures = 0;

  elevator_car_ctrl #(.FLOORS(4), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
    .clk        (clk),
    .emergency  (emergency),
    .req        (req),
    .req_clr    (req_clr),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open)
  );

  always #5 clk = ~clk;

  // One clock: the latch drops whatever bit req_clr was pulsing during the cycle just ended.
  task automatic tick();
    logic [3:0] c;
    c = $isunknown(req_clr) ? 4'b0000 : req_clr;
    @(posedge clk);
    #1;
    req = req & ~c;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [8:0] exp_v(input int f, input logic mu, input logic md,
                                       input logic dr, input logic [3:0] clr);
    return {2'(f), mu, md, dr, clr};
  endfunction

  task automatic chk(input string tag, input logic [8:0] expv);
    logic [8:0] obs;
    obs = {floor, moving_up, moving_down, door_open, req_clr};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b required=%b (floor,up,down,door,req_clr)", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset with every floor requested.
    emergency = 1'b1;
    req       = 4'b1111;
    run(2);
    chk("reset", exp_v(0, 0, 0, 0, 4'b0000));
    emergency = 1'b0;
    tick();
    chk("reset_release_door", exp_v(0, 0, 0, 1, 4'b0001));
    req = req & 4'b0001;              // withdraw floors 1..3 to keep the run directed
    tick();
    chk("door_cycle2_noclr", exp_v(0, 0, 0, 1, 4'b0000));
    run(2);
    chk("door_cycle4", exp_v(0, 0, 0, 1, 4'b0000));
    tick();
    chk("door_done_idle", exp_v(0, 0, 0, 0, 4'b0000));

    // Single trip 0 -> 2.
    req = 4'b0100;
    tick();
    chk("trip_start_up", exp_v(0, 1, 0, 0, 4'b0000));
    run(7);
    chk("trip_still_f0", exp_v(0, 1, 0, 0, 4'b0000));
    tick();
    chk("trip_f1_pass", exp_v(1, 1, 0, 0, 4'b0000));
    run(7);
    chk("trip_f1_end", exp_v(1, 1, 0, 0, 4'b0000));
    tick();
    chk("trip_arrive_f2", exp_v(2, 0, 0, 1, 4'b0100));
    tick();
    run(2);
    chk("trip_door_last", exp_v(2, 0, 0, 1, 4'b0000));
    tick();
    chk("trip_idle_f2", exp_v(2, 0, 0, 0, 4'b0000));

    // Down one floor to 1, then door re-request.
    req = 4'b0010;
    tick();
    chk("down_start", exp_v(2, 0, 1, 0, 4'b0000));
    run(7);
    chk("down_f2_end", exp_v(2, 0, 1, 0, 4'b0000));
    tick();
    chk("down_arrive_f1", exp_v(1, 0, 0, 1, 4'b0010));
    tick();
    chk("rereq_cycle2", exp_v(1, 0, 0, 1, 4'b0000));
    tick();
    chk("rereq_cycle3", exp_v(1, 0, 0, 1, 4'b0000));
    req = req | 4'b0010;
    tick();
    chk("rereq_clr_again", exp_v(1, 0, 0, 1, 4'b0010));
    run(3);
    chk("rereq_cycle7", exp_v(1, 0, 0, 1, 4'b0000));
    tick();
    chk("rereq_idle", exp_v(1, 0, 0, 0, 4'b0000));

    // Direction preserve: moving up from 1 with requests at 3 and 0.
    req = 4'b1000;
    tick();
    chk("dp_start_up", exp_v(1, 1, 0, 0, 4'b0000));
    run(2);
    req = req | 4'b0001;
    run(5);
    chk("dp_f1_end", exp_v(1, 1, 0, 0, 4'b0000));
    tick();
    chk("dp_pass_f2", exp_v(2, 1, 0, 0, 4'b0000));
    run(7);
    tick();
    chk("dp_arrive_f3", exp_v(3, 0, 0, 1, 4'b1000));
    tick();
    run(2);
    tick();
    chk("dp_idle_f3", exp_v(3, 0, 0, 0, 4'b0000));
    tick();
    chk("dp_reverse_down", exp_v(3, 0, 1, 0, 4'b0000));
    run(23);
    chk("dp_f1_down_end", exp_v(1, 0, 1, 0, 4'b0000));
    tick();
    chk("dp_arrive_f0", exp_v(0, 0, 0, 1, 4'b0001));
    tick();
    run(2);
    tick();
    chk("dp_idle_f0", exp_v(0, 0, 0, 0, 4'b0000));

    // Pass-through pickup: heading to 3, floor 2 requested 3 cycles before reaching it.
    req = 4'b1000;
    tick();
    chk("pt_start_up", exp_v(0, 1, 0, 0, 4'b0000));
    run(13);
    chk("pt_f1_t5", exp_v(1, 1, 0, 0, 4'b0000));
    req = req | 4'b0100;
    run(3);
    chk("pt_stop_f2", exp_v(2, 0, 0, 1, 4'b0100));
    tick();
    run(2);
    chk("pt_door_last", exp_v(2, 0, 0, 1, 4'b0000));
    tick();
    chk("pt_idle_f2", exp_v(2, 0, 0, 0, 4'b0000));
    tick();
    chk("pt_continue_up", exp_v(2, 1, 0, 0, 4'b0000));

    // Emergency mid-travel between 2 and 3 at travel timer 5.
    run(5);
    chk("em_before", exp_v(2, 1, 0, 0, 4'b0000));
    emergency = 1'b1;
    tick();
    chk("em_snap_f0", exp_v(0, 0, 0, 0, 4'b0000));
    emergency = 1'b0;
    tick();
    chk("em_resume_up", exp_v(0, 1, 0, 0, 4'b0000));
    run(23);
    chk("em_f2_end", exp_v(2, 1, 0, 0, 4'b0000));
    tick();
    chk("em_serve_f3", exp_v(3, 0, 0, 1, 4'b1000));

    // Emergency during door open forces req_clr low.
    req = 4'b1000;
    tick();
    chk("em_door_cycle2", exp_v(3, 0, 0, 1, 4'b0000));
    emergency = 1'b1;
    tick();
    chk("em_door_reset", exp_v(0, 0, 0, 0, 4'b0000));
    emergency = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
